// File: rtl/beam_power_trigger.sv
// Per-beam sliding-window power trigger: window sum, threshold compare, held
// valid/ready trigger record and holdoff. Optional: BEAM_POWER_TRIGGER_MISSED_EN.
module beam_power_trigger #(
   parameter int  NSAMP   = 4,
   parameter int  SQBITS  = 14,
   parameter int  WINDOW  = 4,
   parameter int  HOLDOFF = 8,
   localparam int PWRBITS = SQBITS + $clog2(NSAMP) + $clog2(WINDOW)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NSAMP*SQBITS-1:0] sq_i,
   input  logic                    sq_valid_i,
   input  logic                    enable_i,
   input  logic [PWRBITS-1:0]      thresh_i,
   input  logic                    thresh_wr_i,
   output logic                    trig_valid_o,
   input  logic                    trig_ready_i,
   output logic [PWRBITS-1:0]      trig_power_o,
   output logic [PWRBITS-1:0]      power_o,
   output logic [15:0]             missed_o
);

   localparam int CSBITS = SQBITS + $clog2(NSAMP);
   localparam int FBITS  = $clog2(WINDOW + 1);
   localparam int HBITS  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [FBITS-1:0] FILL_FULL = FBITS'(WINDOW);
   localparam logic [HBITS-1:0] HOLD_LOAD = HBITS'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FIRE,
      S_HOLD
   } state_t;

   logic [CSBITS-1:0]  w_clk_sum;
   logic [CSBITS-1:0]  r_clk_sum;
   logic               r_s1_valid;

   logic [CSBITS-1:0]  r_dly [WINDOW];
   logic [CSBITS-1:0]  w_oldest;
   logic [FBITS-1:0]   r_fill;
   logic [PWRBITS-1:0] r_win_sum;
   logic               r_s2_upd;

   logic [PWRBITS-1:0] r_thresh;
   logic [PWRBITS-1:0] r_cmp_pwr;
   logic               r_exceed;

   state_t             r_state;
   state_t             w_state_next;
   logic [HBITS-1:0]   r_hold_cnt;
   logic [HBITS-1:0]   w_hold_next;
   logic [PWRBITS-1:0] r_trig_power;
   logic [PWRBITS-1:0] w_trig_power_next;

   // Stage 1: per-clock sum of all samples, wide enough to never overflow.
   always_comb begin
      w_clk_sum = '0;
      for (int k = 0; k < NSAMP; k++) begin
         w_clk_sum = w_clk_sum + CSBITS'(sq_i[SQBITS*k +: SQBITS]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_clk_sum  <= '0;
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= sq_valid_i & enable_i;
         if (sq_valid_i) begin
            r_clk_sum <= w_clk_sum;
         end
      end
   end

   // Stage 2: running window sum; the tap leaving the window counts as zero
   // until the delay line holds WINDOW valid entries.
   assign w_oldest = (r_fill == FILL_FULL) ? r_dly[WINDOW-1] : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < WINDOW; i++) begin
            r_dly[i] <= '0;
         end
         r_fill    <= '0;
         r_win_sum <= '0;
         r_s2_upd  <= 1'b0;
      end else if (!enable_i) begin
         for (int i = 0; i < WINDOW; i++) begin
            r_dly[i] <= '0;
         end
         r_fill    <= '0;
         r_win_sum <= '0;
         r_s2_upd  <= 1'b0;
      end else begin
         r_s2_upd <= r_s1_valid;
         if (r_s1_valid) begin
            r_dly[0] <= r_clk_sum;
            for (int i = 1; i < WINDOW; i++) begin
               r_dly[i] <= r_dly[i-1];
            end
            r_win_sum <= r_win_sum + PWRBITS'(r_clk_sum) - PWRBITS'(w_oldest);
            if (r_fill != FILL_FULL) begin
               r_fill <= r_fill + FBITS'(1);
            end
         end
      end
   end

   assign power_o = r_win_sum;

   // Stage 3: strict compare against the threshold as it stood before any
   // same-clock write; the compared sum travels with the exceed pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_thresh  <= '1;
         r_cmp_pwr <= '0;
         r_exceed  <= 1'b0;
      end else begin
         if (thresh_wr_i) begin
            r_thresh <= thresh_i;
         end
         r_exceed <= enable_i & r_s2_upd & (r_fill == FILL_FULL) & (r_win_sum > r_thresh);
         if (r_s2_upd) begin
            r_cmp_pwr <= r_win_sum;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= S_IDLE;
         r_hold_cnt   <= '0;
         r_trig_power <= '0;
      end else begin
         r_state      <= w_state_next;
         r_hold_cnt   <= w_hold_next;
         r_trig_power <= w_trig_power_next;
      end
   end

   // The record is frozen outside IDLE, so it only changes while no record is offered.
   always_comb begin
      w_state_next      = r_state;
      w_hold_next       = r_hold_cnt;
      w_trig_power_next = r_trig_power;
      if (!enable_i) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_exceed) begin
                  w_trig_power_next = r_cmp_pwr;
                  w_state_next      = S_FIRE;
               end
            end
            S_FIRE: begin
               if (trig_ready_i) begin
                  w_state_next = S_HOLD;
                  w_hold_next  = HOLD_LOAD;
               end
            end
            S_HOLD: begin
               if (r_hold_cnt == '0) begin
                  w_state_next = S_IDLE;
               end else begin
                  w_hold_next = r_hold_cnt - HBITS'(1);
               end
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   assign trig_valid_o = (r_state == S_FIRE);
   assign trig_power_o = r_trig_power;

`ifdef BEAM_POWER_TRIGGER_MISSED_EN
   logic [15:0] r_missed;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_missed <= '0;
      end else if (!enable_i) begin
         r_missed <= '0;
      end else if (r_exceed && (r_state != S_IDLE) && (r_missed != 16'hFFFF)) begin
         r_missed <= r_missed + 16'd1;
      end
   end

   assign missed_o = r_missed;
`else
   assign missed_o = 16'd0;
`endif

endmodule

// File: tb/tb_beam_power_trigger.sv
// Bench for beam_power_trigger: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based window/trigger model.
module tb_beam_power_trigger;

   localparam int NSAMP   = 4;
   localparam int SQBITS  = 14;
   localparam int WINDOW  = 4;
   localparam int HOLDOFF = 8;
   localparam int PWRBITS = 18;

   logic                    clk_i = 1'b0;
   logic                    rst_ni = 1'b0;
   logic [NSAMP*SQBITS-1:0] sq_i = '0;
   logic                    sq_valid_i = 1'b0;
   logic                    enable_i = 1'b0;
   logic [PWRBITS-1:0]      thresh_i = '0;
   logic                    thresh_wr_i = 1'b0;
   logic                    trig_valid_o;
   logic                    trig_ready_i = 1'b0;
   logic [PWRBITS-1:0]      trig_power_o;
   logic [PWRBITS-1:0]      power_o;
   logic [15:0]             missed_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   int q_win[$];
   int m_pwr, m_s1sum, m_cmp, m_thresh, m_hold, m_tp, m_missed;
   bit m_s1v, m_upd, m_exc, m_valid;

   always #5 clk_i = ~clk_i;

   beam_power_trigger #(
      .NSAMP  (NSAMP),
      .SQBITS (SQBITS),
      .WINDOW (WINDOW),
      .HOLDOFF(HOLDOFF)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .sq_i        (sq_i),
      .sq_valid_i  (sq_valid_i),
      .enable_i    (enable_i),
      .thresh_i    (thresh_i),
      .thresh_wr_i (thresh_wr_i),
      .trig_valid_o(trig_valid_o),
      .trig_ready_i(trig_ready_i),
      .trig_power_o(trig_power_o),
      .power_o     (power_o),
      .missed_o    (missed_o)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int input_sum();
      int s = 0;
      for (int k = 0; k < NSAMP; k++) s += int'(sq_i[SQBITS*k +: SQBITS]);
      return s;
   endfunction

   task automatic reset_model();
      q_win.delete();
      m_pwr = 0; m_s1sum = 0; m_cmp = 0; m_thresh = (1 << PWRBITS) - 1;
      m_hold = 0; m_tp = 0; m_missed = 0;
      m_s1v = 0; m_upd = 0; m_exc = 0; m_valid = 0;
   endtask

   // One clock of the reference: the window is simply the last WINDOW valid
   // clock sums; compare/trigger decisions use values from before this edge.
   task automatic model_step();
      bit o_s1v   = m_s1v;
      int o_s1sum = m_s1sum;
      bit o_upd   = m_upd;
      bit o_exc   = m_exc;
      int o_cmp   = m_cmp;
      int o_thr   = m_thresh;
      bit busy    = m_valid || (m_hold > 0);
      if (thresh_wr_i) m_thresh = int'(thresh_i);
      if (sq_valid_i) m_s1sum = input_sum();
      if (!enable_i) begin
         q_win.delete();
         m_pwr = 0; m_s1v = 0; m_upd = 0; m_exc = 0;
         m_valid = 0; m_hold = 0; m_missed = 0;
         return;
      end
      m_exc = o_upd && (q_win.size() == WINDOW) && (m_pwr > o_thr);
      if (o_upd) m_cmp = m_pwr;
      if (o_s1v) begin
         q_win.push_back(o_s1sum);
         if (q_win.size() > WINDOW) void'(q_win.pop_front());
         m_pwr = 0;
         foreach (q_win[i]) m_pwr += q_win[i];
      end
      m_upd = o_s1v;
      m_s1v = sq_valid_i;
`ifdef BEAM_POWER_TRIGGER_MISSED_EN
      if (busy && o_exc && m_missed < 65535) m_missed++;
`else
      if (busy && o_exc) m_missed = 0;
`endif
      if (m_valid) begin
         if (trig_ready_i) begin
            m_valid = 0;
            m_hold  = HOLDOFF;
         end
      end else if (m_hold > 0) begin
         m_hold--;
      end else if (o_exc) begin
         m_valid = 1;
         m_tp    = o_cmp;
      end
   endtask

   initial begin
      reset_model();
      forever begin
         @(posedge clk_i or negedge rst_ni);
         if (!rst_ni) reset_model();
         else model_step();
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk_i);
         check("cyc_trig_valid", trig_valid_o, m_valid);
         check("cyc_trig_power", trig_power_o, m_tp);
         check("cyc_power", power_o, m_pwr);
         check("cyc_missed", missed_o, m_missed);
         if (trig_valid_o && trig_ready_i && rst_ni && enable_i)
            $display("[TB] trigger accepted power=%0d t=%0t", trig_power_o, $time);
      end
   end

   task automatic set_all(input int v);
      for (int k = 0; k < NSAMP; k++) sq_i[SQBITS*k +: SQBITS] = SQBITS'(v);
   endtask

   // Flush with enable low for one clock while loading the threshold.
   task automatic prog_thresh(input int v);
      enable_i    = 1'b0;
      thresh_i    = PWRBITS'(v);
      thresh_wr_i = 1'b1;
      @(negedge clk_i);
      thresh_wr_i = 1'b0;
      enable_i    = 1'b1;
   endtask

   task automatic wait_fire(input int max_clk, output int at);
      at = -1;
      for (int i = 1; i <= max_clk; i++) begin
         @(negedge clk_i);
         if (trig_valid_o) begin
            at = i;
            return;
         end
      end
   endtask

   initial begin
      int fired, first1, first2, at, stable;

      repeat (3) @(negedge clk_i);
      check("rst_trig_valid", trig_valid_o, 0);
      check("rst_trig_power", trig_power_o, 0);
      check("rst_power", power_o, 0);
      check("rst_missed", missed_o, 0);
      #2 rst_ni = 1'b1;

      // Full-scale input, default threshold: sum saturates the window but never fires.
      set_all(16383); sq_valid_i = 1'b1; enable_i = 1'b1; trig_ready_i = 1'b1;
      fired = 0;
      repeat (20) begin
         @(negedge clk_i);
         if (trig_valid_o) fired++;
      end
      check("max_power", power_o, 262128);
      check("max_nofire", fired, 0);

      // Ramp 400..1600, fire 3 clocks after the window fills, then holdoff.
      prog_thresh(1599); set_all(100);
      first1 = -1; first2 = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk_i);
         if (i >= 2 && i <= 5) check($sformatf("ramp_power_%0d", i), power_o, 400 * (i - 1));
         if (trig_valid_o) begin
            if (first1 < 0) begin
               first1 = i;
               check("first_trig_power", trig_power_o, 1600);
            end else if (first2 < 0) begin
               first2 = i;
            end
         end
      end
      check("first_fire_clk", first1, 7);
      check("second_fire_clk", first2, 7 + 2 + HOLDOFF);

      // Strict compare: equal does not fire; lowering the threshold does.
      prog_thresh(1600);
      fired = 0;
      repeat (15) begin
         @(negedge clk_i);
         if (trig_valid_o) fired++;
      end
      check("equal_nofire", fired, 0);
      thresh_i = 18'd1599; thresh_wr_i = 1'b1;
      @(negedge clk_i);
      thresh_wr_i = 1'b0;
      wait_fire(4, at);
      check("rewrite_fire_clk", at, 2);

      // Back-pressure: record held stable for 20 clocks.
      trig_ready_i = 1'b0;
      prog_thresh(1599);
      wait_fire(12, at);
      check("hold_fire_clk", at, 7);
      stable = 0;
      repeat (20) begin
         @(negedge clk_i);
         if (trig_valid_o && trig_power_o == 18'd1600) stable++;
      end
      check("hold_stable", stable, 20);
`ifdef BEAM_POWER_TRIGGER_MISSED_EN
      check("hold_missed", missed_o, 20);
`endif
      trig_ready_i = 1'b1;
      @(negedge clk_i);
      check("hold_released", trig_valid_o, 0);

      // Valid every other clock: window advances only on valid clocks.
      prog_thresh(1599);
      first1 = -1;
      for (int i = 1; i <= 14; i++) begin
         sq_valid_i = (i % 2) == 1;
         @(negedge clk_i);
         if (i == 3) check("toggle_power_hold", power_o, 400);
         if (i == 4) check("toggle_power_step", power_o, 800);
         if (trig_valid_o && first1 < 0) first1 = i;
      end
      check("toggle_fire_clk", first1, 10);
      sq_valid_i = 1'b1;

      // Drop enable while a record is offered.
      trig_ready_i = 1'b0;
      wait_fire(30, at);
      check("en_reach_fire", (at > 0) ? 1 : 0, 1);
      enable_i = 1'b0;
      @(negedge clk_i);
      check("en_valid_drop", trig_valid_o, 0);
      check("en_power_clear", power_o, 0);
      enable_i = 1'b1;
      wait_fire(20, at);
      check("en_refire_clk", at, 7);

      // Randomized traffic, including enable drops and asynchronous resets.
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NSAMP; k++) sq_i[SQBITS*k +: SQBITS] = SQBITS'($urandom_range(0, 200));
         sq_valid_i   = ($urandom_range(0, 9) < 8);
         trig_ready_i = $urandom_range(0, 1) == 1;
         thresh_wr_i  = ($urandom_range(0, 49) == 0);
         thresh_i     = PWRBITS'($urandom_range(1200, 2000));
         enable_i     = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_ni = 1'b0;
            @(negedge clk_i);
            #2 rst_ni = 1'b1;
         end else begin
            @(negedge clk_i);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
